bus_trace_sequencer: RTL and testbench
======================================

// Module: bus_trace_sequencer
// PURPOSE
//  Captures Z80 bus cycles that fall in a configurable address window into a FIFO.
//  Formats each captured cycle as an ASCII hex trace line.
//  Sequences the characters one at a time into the uart_tx byte transmitter.
//  Sits between the RC2014 bus pins and uart_tx, and replaces the free-running single-sample debug print.
// PARAMETERS
//  FIFO_DEPTH  16        entries, power of 2, >=2
//  ADDR_LO     16'h2000  window low bound, inclusive
//  ADDR_HI     16'h7FFF  window high bound, inclusive
//  CAPTURE_IO  0         1: also capture IORQ cycles, with no window check
// PORTS
//  CLK         in   1   system clock
//  reset       in   1   synchronous, active-high
//  bus_a       in   16  Z80 address, asynchronous to CLK
//  bus_d       in   8   Z80 data as seen by the FPGA input buffer
//  bus_mreq_n  in   1   active-low memory request
//  bus_iorq_n  in   1   active-low I/O request
//  bus_rd_n    in   1   active-low read strobe
//  bus_wr_n    in   1   active-low write strobe
//  enable      in   1   1 = capture new cycles
//  tx_req      out  1   byte valid to uart_tx
//  tx_data     out  8   ASCII byte
//  tx_ready    in   1   uart_tx can accept a byte
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
//  drop_count  out  8   cycles lost to FIFO full, saturating at 8'hFF
//  busy        out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset: reset is synchronous, active-high; clock is CLK.
//   tx_req=0, tx_data=0, fifo_level=0, drop_count=0, busy=0.
//   The FIFO is emptied, the FSM enters IDLE, and synchronizers are loaded with the inactive level (1).
//   A reset mid-line abandons the partial line; tx_req is 0 from the next edge.
//  Sync: all bus_* inputs pass through a 2-flop synchronizer. All decisions use the synchronized copies.
//  Active condition: act = !rd_n|!wr_n, ANDed with one of:
//   !mreq_n && ADDR_LO<=a<=ADDR_HI
//   (CAPTURE_IO && !iorq_n)
//  Sampling: while act=1, the {a, d, is_wr, is_io} register reloads every cycle.
//  Push: occurs on the edge where act falls 1->0 and enable=1. One push per bus cycle; the last sample is pushed.
//  Full: a push is accepted if the FIFO is not full OR a pop happens on the same edge.
//   Otherwise the entry is dropped and drop_count increments, saturating.
//  FSM:
//   IDLE: move to LOAD when fifo_level!=0.
//   LOAD: pop the head into the line register, set idx=0, move to SEND.
//   SEND: tx_req=1 with tx_data=char(idx). The handshake completes on an edge where tx_req&&tx_ready.
//    On completion: if idx==LINE_LEN-1, go to LOAD if fifo_level!=0, else IDLE. Otherwise idx++.
//    tx_data is stable while tx_req=1 and tx_ready=0.
//  Latency: tx_req=1 exactly 2 edges after the push edge when the FSM was IDLE.
//  Line format, LINE_LEN=11: D ' ' H3 H2 H1 H0 '=' V1 V0 CR LF
//   D = 'R'/'W' for memory cycles, 'I'/'O' for I/O cycles.
//   Hex digits are uppercase.
//  enable=0 stops pushes only. A line in flight completes and the FIFO drains.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined:
//   A 16-bit free-running CLK counter (wraps at FFFF, 0 at reset) is stored with each entry at the push edge.
//   The line becomes D ' ' HHHH '=' VV ' ' 't' TTTT CR LF, with LINE_LEN=17.
//  TRACE_TIMESTAMP_EN undefined: no counter, entries have no timestamp field, LINE_LEN=11.
// STRUCTURE
//  Package rc2014_trace_pkg holds:
//   trace_entry_t {is_io, is_wr, addr[15:0], data[7:0], optional ts[15:0]}
//   LINE_LEN_BASE=11, LINE_LEN_TS=17, ASCII constants (CR=8'h0D, LF=8'h0A)
//   function hex_ascii(nibble) returning "0".."F"
//  Sub-module trace_fifo is a synchronous single-clock FIFO of trace_entry_t with full/empty/level outputs.
//  The FSM, synchronizer and formatter live in this module.
// TESTING
//  1. Write 8'h4F to 16'h2123, tx_ready=1 held.
//     -> "W 2123=4F\r\n", 11 bytes. tx_req rises 2 edges after the push.
//  2. Read 16'h1000 and write 16'h8000 (both outside the window).
//     -> no push, tx_req stays 0, fifo_level=0.
//  3. 20 window writes back-to-back with tx_ready=0, FIFO_DEPTH=16.
//     -> fifo_level=16 after the pops stall.
//     -> drop_count=3 (one entry already popped into the line register).
//  4. Toggle tx_ready 1/0 every cycle during a line.
//     -> tx_data holds until each accept, no byte is skipped or duplicated.
//  5. Assert reset at byte 5 of a line.
//     -> tx_req=0 next edge, fifo_level=0, drop_count=0. The next write prints a complete fresh line.
//  6. CAPTURE_IO=1 and OUT (0x00C0),0x55.
//     -> "O 00C0=55\r\n". With TRACE_TIMESTAMP_EN, the line is 17 bytes ending " tXXXX\r\n".

Source files
------------

// File: rtl/rc2014_trace_pkg.sv
// Shared types and helpers for the RC2014 bus trace sequencer.
// Optional build macro: TRACE_TIMESTAMP_EN adds a 16-bit timestamp to each entry
// and lengthens the printed line from 11 to 17 characters.
package rc2014_trace_pkg;

  localparam int LINE_LEN_BASE = 11;
  localparam int LINE_LEN_TS   = 17;

`ifdef TRACE_TIMESTAMP_EN
  localparam int LINE_LEN = LINE_LEN_TS;
`else
  localparam int LINE_LEN = LINE_LEN_BASE;
`endif

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_T     = 8'h74;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_I     = 8'h49;
  localparam logic [7:0] ASCII_O     = 8'h4F;

  typedef struct packed {
    logic        is_io;
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;
`endif
  } trace_entry_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10)
      return 8'h30 + {4'h0, nibble};
    else
      return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO of trace entries. Storage has no reset so it maps onto block RAM.
// rd_entry is registered: it shows the head as it stood at the previous edge, so a
// consumer must wait one cycle after level becomes non-zero before taking it.
module trace_fifo
  import rc2014_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       push,
  input  trace_entry_t               wr_entry,
  input  logic                       pop,
  output trace_entry_t               rd_entry,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);

  trace_entry_t           mem [DEPTH];
  trace_entry_t           rd_entry_reg;
  logic [PW-1:0]          wr_ptr_reg;
  logic [PW-1:0]          rd_ptr_reg;
  logic [PW:0]            level_reg;
  logic                   push_ok;
  logic                   pop_ok;

  assign full     = (level_reg == (PW+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign rd_entry = rd_entry_reg;

  // A push into a full FIFO is still taken when the same edge frees a slot.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage write port and registered read of the current head.
  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr_reg] <= wr_entry;
    rd_entry_reg <= mem[rd_ptr_reg];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/bus_trace_sequencer.sv
// Captures Z80 bus cycles inside an address window (and optionally I/O cycles),
// queues them, and streams each one to uart_tx as an ASCII hex line.
// Optional build macro: TRACE_TIMESTAMP_EN appends " tTTTT" from a free-running counter.
module bus_trace_sequencer
  import rc2014_trace_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] ADDR_LO    = 16'h2000,
  parameter logic [15:0] ADDR_HI    = 16'h7FFF,
  parameter int          CAPTURE_IO = 0
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [15:0]                   bus_a,
  input  logic [7:0]                    bus_d,
  input  logic                          bus_mreq_n,
  input  logic                          bus_iorq_n,
  input  logic                          bus_rd_n,
  input  logic                          bus_wr_n,
  input  logic                          enable,
  output logic                          tx_req,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count,
  output logic                          busy
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Bus bundle: {a[15:0], d[7:0], mreq_n, iorq_n, rd_n, wr_n}
  logic [27:0]  bus_meta_reg;
  logic [27:0]  bus_sync_reg;
  logic [15:0]  a_sync;
  logic [7:0]   d_sync;
  logic         mreq_n_sync, iorq_n_sync, rd_n_sync, wr_n_sync;

  logic         mem_hit, io_hit, act;
  logic         act_reg;
  logic         push;
  trace_entry_t sample_reg;
  trace_entry_t push_entry;
  trace_entry_t head_entry;
  trace_entry_t line_reg;
  logic         fifo_full, fifo_empty, fifo_pop;
  logic [LW-1:0] level;
  logic [7:0]   drop_count_reg;
  logic [1:0]   state_reg;
  logic [4:0]   idx_reg;
  logic [7:0]   line_char;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]  ts_cnt_reg;

  // Free-running cycle stamp, wraps naturally.
  always_ff @(posedge CLK) begin
    if (reset)
      ts_cnt_reg <= '0;
    else
      ts_cnt_reg <= ts_cnt_reg + 16'd1;
  end
`endif

  // Two-flop synchronizer for every bus pin; idles at the inactive (all-ones) level.
  always_ff @(posedge CLK) begin
    if (reset) begin
      bus_meta_reg <= '1;
      bus_sync_reg <= '1;
    end else begin
      bus_meta_reg <= {bus_a, bus_d, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n};
      bus_sync_reg <= bus_meta_reg;
    end
  end

  assign {a_sync, d_sync, mreq_n_sync, iorq_n_sync, rd_n_sync, wr_n_sync} = bus_sync_reg;

  // A cycle of interest: a strobe plus either an in-window memory access or an I/O access.
  always_comb begin
    mem_hit = !mreq_n_sync && (a_sync >= ADDR_LO) && (a_sync <= ADDR_HI);
    io_hit  = (CAPTURE_IO != 0) && !iorq_n_sync;
    act     = (!rd_n_sync || !wr_n_sync) && (mem_hit || io_hit);
  end

  // Track the last sample of the active cycle; the push uses it after the strobe ends.
  always_ff @(posedge CLK) begin
    if (reset) begin
      act_reg    <= 1'b0;
      sample_reg <= '0;
    end else begin
      act_reg <= act;
      if (act) begin
        sample_reg.is_io <= !mem_hit;
        sample_reg.is_wr <= !wr_n_sync;
        sample_reg.addr  <= a_sync;
        sample_reg.data  <= d_sync;
      end
    end
  end

  assign push = act_reg && !act && enable;

  // Entry written to the FIFO: the held sample plus, if built in, the stamp at the push edge.
  always_comb begin
    push_entry = sample_reg;
`ifdef TRACE_TIMESTAMP_EN
    push_entry.ts = ts_cnt_reg;
`endif
  end

  assign fifo_pop = (state_reg == ST_LOAD) && !fifo_empty;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (push),
    .wr_entry (push_entry),
    .pop      (fifo_pop),
    .rd_entry (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  // Count cycles lost to a full FIFO, saturating so it never wraps back to a small number.
  always_ff @(posedge CLK) begin
    if (reset)
      drop_count_reg <= '0;
    else if (push && fifo_full && !fifo_pop && (drop_count_reg != 8'hFF))
      drop_count_reg <= drop_count_reg + 8'd1;
  end

  // Line sequencer: wait for an entry, latch it, then hand out one character per accept.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      line_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (level != '0)
            state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          line_reg  <= head_entry;
          idx_reg   <= '0;
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (idx_reg == LAST_IDX)
              state_reg <= (level != '0) ? ST_LOAD : ST_IDLE;
            else
              idx_reg <= idx_reg + 5'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Character at the current line position.
  always_comb begin
    line_char = 8'h00;
    case (idx_reg)
      5'd0:  line_char = line_reg.is_io ? (line_reg.is_wr ? ASCII_O : ASCII_I)
                                        : (line_reg.is_wr ? ASCII_W : ASCII_R);
      5'd1:  line_char = ASCII_SPACE;
      5'd2:  line_char = hex_ascii(line_reg.addr[15:12]);
      5'd3:  line_char = hex_ascii(line_reg.addr[11:8]);
      5'd4:  line_char = hex_ascii(line_reg.addr[7:4]);
      5'd5:  line_char = hex_ascii(line_reg.addr[3:0]);
      5'd6:  line_char = ASCII_EQ;
      5'd7:  line_char = hex_ascii(line_reg.data[7:4]);
      5'd8:  line_char = hex_ascii(line_reg.data[3:0]);
`ifdef TRACE_TIMESTAMP_EN
      5'd9:  line_char = ASCII_SPACE;
      5'd10: line_char = ASCII_T;
      5'd11: line_char = hex_ascii(line_reg.ts[15:12]);
      5'd12: line_char = hex_ascii(line_reg.ts[11:8]);
      5'd13: line_char = hex_ascii(line_reg.ts[7:4]);
      5'd14: line_char = hex_ascii(line_reg.ts[3:0]);
      5'd15: line_char = ASCII_CR;
      5'd16: line_char = ASCII_LF;
`else
      5'd9:  line_char = ASCII_CR;
      5'd10: line_char = ASCII_LF;
`endif
      default: line_char = 8'h00;
    endcase
  end

  assign tx_req     = (state_reg == ST_SEND);
  assign tx_data    = tx_req ? line_char : 8'h00;
  assign busy       = (state_reg != ST_IDLE);
  assign fifo_level = level;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_bus_trace_sequencer.sv
// Scoreboard bench for bus_trace_sequencer: each captured bus cycle pushes its
// expected ASCII line into a queue; a monitor pops one byte per tx handshake.
module tb_bus_trace_sequencer;

`ifdef TRACE_TIMESTAMP_EN
  localparam int LINE_LEN = 17;
`else
  localparam int LINE_LEN = 11;
`endif
  localparam int DEPTH = 16;
  localparam int CAP_IO = 1;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n;
  logic        enable;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        busy;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          rx_count = 0;
  int          rdy_mode = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] bench_cnt;
  bit          hold_valid = 0;
  logic [7:0]  held_byte;

  bus_trace_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_LO    (16'h2000),
    .ADDR_HI    (16'h7FFF),
    .CAPTURE_IO (CAP_IO)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .bus_a      (bus_a),
    .bus_d      (bus_d),
    .bus_mreq_n (bus_mreq_n),
    .bus_iorq_n (bus_iorq_n),
    .bus_rd_n   (bus_rd_n),
    .bus_wr_n   (bus_wr_n),
    .enable     (enable),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Reference cycle counter: 0 at reset, +1 per clock otherwise.
  always @(posedge CLK) bench_cnt <= reset ? 16'd0 : bench_cnt + 16'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 10) ? (8'd48 + 8'(n)) : (8'd55 + 8'(n));
  endfunction

  // Reference formatter: builds the whole line from the cycle description.
  task automatic push_line(input logic [15:0] a, input logic [7:0] d, input bit wr,
                           input bit io, input logic [15:0] ts);
    logic [7:0] c;
    if (io) c = wr ? "O" : "I";
    else    c = wr ? "W" : "R";
    exp_q.push_back(c);
    exp_q.push_back(" ");
    for (int s = 12; s >= 0; s -= 4) exp_q.push_back(hexc(4'((a >> s) & 16'hF)));
    exp_q.push_back("=");
    exp_q.push_back(hexc(d[7:4]));
    exp_q.push_back(hexc(d[3:0]));
`ifdef TRACE_TIMESTAMP_EN
    exp_q.push_back(" ");
    exp_q.push_back("t");
    for (int s = 12; s >= 0; s -= 4) exp_q.push_back(hexc(4'((ts >> s) & 16'hF)));
`else
    if (ts == 16'hFFFF) c = 8'h00;  // timestamp unused in this build
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // One Z80 bus cycle; called and returns at posedge+1.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input bit wr,
                           input bit io, input bit expect_it);
    logic [15:0] ts;
    bit captured;
    bus_a = a;
    bus_d = d;
    if (io) bus_iorq_n = 1'b0; else bus_mreq_n = 1'b0;
    if (wr) bus_wr_n = 1'b0; else bus_rd_n = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge CLK);
    #1;
    bus_mreq_n = 1'b1; bus_iorq_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    ts = bench_cnt;
    captured = enable && (io ? (CAP_IO != 0) : (a >= 16'h2000 && a <= 16'h7FFF));
    if (captured && expect_it) push_line(a, d, wr, io, ts);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_q.size());
    end
  endtask

  // tx_ready driver: held high, held low, toggling, or random.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'b0;
        2: tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each accepted byte, and check tx_data holds while stalled.
  always @(negedge CLK) begin
    if (reset) begin
      hold_valid = 0;
    end else if (tx_req) begin
      if (hold_valid) chk("hold", 32'(tx_data), 32'(held_byte));
      if (tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_byte: got %02h expected none", tx_data);
        end else begin
          chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        rx_count++;
        hold_valid = 0;
      end else begin
        hold_valid = 1;
        held_byte  = tx_data;
      end
    end else begin
      hold_valid = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base, n;
    logic [15:0] ra;
    reset = 1'b1; enable = 1'b1;
    bus_a = 16'h0000; bus_d = 8'h00;
    bus_mreq_n = 1'b1; bus_iorq_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tx_req", 32'(tx_req), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge CLK); #1; reset = 1'b0;

    // 1: single in-window write, latency from push to tx_req
    rdy_mode = 0;
    base = rx_count;
    fork
      bus_cycle(16'h2123, 8'h4F, 1, 0, 1);
      begin
        n = 0;
        @(negedge CLK);
        while (fifo_level == 0 && n < 40) begin @(negedge CLK); n++; end
        if (n >= 40) begin
          n_cmp++; n_fail++;
          $display("FAIL push_timeout: got level 0 expected 1");
        end else begin
          chk("lat_push", 32'(tx_req), 0);
          @(negedge CLK); chk("lat_e1", 32'(tx_req), 0);
          @(negedge CLK); chk("lat_e2", 32'(tx_req), 1);
        end
      end
    join
    wait_drain("t1");
    chk("t1_len", 32'(rx_count - base), 32'(LINE_LEN));

    // 2: outside the window
    base = rx_count;
    bus_cycle(16'h1000, 8'hAA, 0, 0, 1);
    bus_cycle(16'h8000, 8'h55, 1, 0, 1);
    repeat (8) @(posedge CLK); #1;
    chk("t2_level", 32'(fifo_level), 0);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_bytes", 32'(rx_count - base), 0);

    // 3: overflow with the transmitter stalled
    rdy_mode = 1;
    for (int i = 0; i < 20; i++)
      bus_cycle(16'h3000 + 16'(i), 8'(i * 7), 1, 0, (i < 17) ? 1'b1 : 1'b0);
    repeat (3) @(posedge CLK); #1;
    chk("t3_level", 32'(fifo_level), 16);
    chk("t3_drop", 32'(drop_count), 3);
    rdy_mode = 0;
    wait_drain("t3");

    // 4: tx_ready toggling during a line
    rdy_mode = 2;
    base = rx_count;
    bus_cycle(16'h7FFF, 8'hC3, 0, 0, 1);
    wait_drain("t4");
    chk("t4_len", 32'(rx_count - base), 32'(LINE_LEN));

    // 5: reset in the middle of a line
    rdy_mode = 0;
    base = rx_count;
    bus_cycle(16'h2000, 8'h01, 1, 0, 1);
    n = 0;
    while (rx_count < base + 5 && n < 200) begin @(posedge CLK); #1; n++; end
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("t5_tx_req", 32'(tx_req), 0);
    chk("t5_level", 32'(fifo_level), 0);
    chk("t5_drop", 32'(drop_count), 0);
    chk("t5_busy", 32'(busy), 0);
    exp_q.delete();
    @(posedge CLK); #1; reset = 1'b0;
    base = rx_count;
    bus_cycle(16'h5A5A, 8'hE7, 1, 0, 1);
    wait_drain("t5");
    chk("t5_len", 32'(rx_count - base), 32'(LINE_LEN));

    // 6: I/O write
    base = rx_count;
    bus_cycle(16'h00C0, 8'h55, 1, 1, 1);
    wait_drain("t6");
    chk("t6_len", 32'(rx_count - base), 32'(LINE_LEN));

    // Random traffic, paced so the FIFO never overflows
    rdy_mode = 3;
    for (int i = 0; i < 60; i++) begin
      n = 0;
      while (fifo_level >= 5'(DEPTH - 1) && n < 2000) begin @(posedge CLK); #1; n++; end
      case ($urandom_range(0, 5))
        0: ra = 16'h1FFF;
        1: ra = 16'h8000;
        2: ra = 16'($urandom_range(0, 65535));
        default: ra = 16'($urandom_range(16'h2000, 16'h7FFF));
      endcase
      enable = ($urandom_range(0, 9) != 0);
      bus_cycle(ra, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 1);
    end
    enable = 1'b1;
    wait_drain("rand");
    chk("rand_drop", 32'(drop_count), 0);
    chk("rand_level", 32'(fifo_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
